cdp1802_dma_out_responder: RTL and testbench

//  CPU-side responder for the CDP1861 (Pixie) DMA-out and interrupt protocol. It sequences
//  CDP1802 machine cycles (S0 fetch, S1 execute, S2 DMA, S3 interrupt) and drives SC[1:0].
//  On an active-low DMAO request it inserts S2 cycles that read memory at R0, post-increment R0
//  and hand each byte to the video block. On INT with IE set it inserts one S3 cycle.
//  It sits between the CPU core, which stalls while SC is S2 or S3, the memory bus and the Pixie.

---
 rtl/cdp1802_dma_out_responder.sv | 204 ++++++++++++++++++++
 tb/tb_cdp1802_dma_out_responder.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdp1802_dma_out_responder.sv
// -----------------------------------------------------------------------------
// cdp1802_dma_out_responder
//
// Purpose:
//   CPU-side machine-cycle sequencer for the CDP1861 (Pixie) DMA-out and
//   interrupt handshake. Each machine cycle is TICKS_PER_CYCLE clk_enable
//   ticks long. The block walks S0 (fetch) / S1 (execute) and, on request,
//   inserts S2 (DMA-out) cycles that read memory at R0 and post-increment it,
//   or a single S3 (interrupt) cycle. The core stalls while SC is S2 or S3.
//
// Ports:
//   clk         system clock
//   reset       synchronous reset, active low
//   clk_enable  CPU clock enable; nothing advances while it is low
//   dmao_n      DMA-out request from the Pixie, active low (sampled at cycle end)
//   int_req     interrupt request from the Pixie (sampled at cycle end)
//   core_hold   core wants another S1 (sampled at cycle end)
//   r0_wr       core write strobe for R0 (honoured in S0/S1 only)
//   r0_wdata    value written to R0
//   ie_set      core sets IE
//   mem_data    memory read data
//   SC          state code: 00 S0, 01 S1, 10 S2, 11 S3
//   mem_addr    DMA read address, loaded from R0 during S2
//   mem_rd      one-clock read strobe during S2
//   dma_data    byte handed to the Pixie
//   dma_strobe  one-clock pulse when dma_data is updated
//   int_ack     one-clock pulse on the first tick of S3
//   r0          current R0 value
//   ie          interrupt-enable flag
// -----------------------------------------------------------------------------
module cdp1802_dma_out_responder #(
    parameter int TICKS_PER_CYCLE = 8,
    parameter int ADDR_TICK       = 3,
    parameter int DATA_TICK       = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        dmao_n,
    input  logic        int_req,
    input  logic        core_hold,
    input  logic        r0_wr,
    input  logic [15:0] r0_wdata,
    input  logic        ie_set,
    input  logic [7:0]  mem_data,
    output logic [1:0]  SC,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic [7:0]  dma_data,
    output logic        dma_strobe,
    output logic        int_ack,
    output logic [15:0] r0,
    output logic        ie
);

    // The tick counter is fixed at 3 bits (8 ticks per machine cycle).
    localparam logic [2:0] LAST_TICK = 3'(TICKS_PER_CYCLE - 1);
    localparam logic [2:0] ADDR_T    = 3'(ADDR_TICK);
    localparam logic [2:0] DATA_T    = 3'(DATA_TICK);

    typedef enum logic [1:0] {
        ST_S0 = 2'b00,
        ST_S1 = 2'b01,
        ST_S2 = 2'b10,
        ST_S3 = 2'b11
    } state_t;

    state_t      state_q, state_d, state_nxt;
    logic [2:0]  tick_q, tick_d;
    logic [15:0] r0_q, r0_d;
    logic        ie_q, ie_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  dma_data_q, dma_data_d;
    logic        mem_rd_q, mem_rd_d;
    logic        dma_strobe_q, dma_strobe_d;
    logic        int_ack_q, int_ack_d;
    logic        cycle_end;

    // R0 post-increment wraps 0xFFFF -> 0x0000.
    function automatic logic [15:0] r0_inc(input logic [15:0] v);
        return v + 16'd1;
    endfunction

    assign cycle_end = clk_enable && (tick_q == LAST_TICK);

    // Next machine cycle, in priority order. An S3 never repeats itself:
    // it is exactly one cycle, optionally followed by DMA.
    always_comb begin
        state_nxt = ST_S0;
        case (state_q)
            ST_S0: state_nxt = ST_S1;
            ST_S1: begin
                if (core_hold)
                    state_nxt = ST_S1;
                else if (!dmao_n)
                    state_nxt = ST_S2;
                else if (int_req && ie_q)
                    state_nxt = ST_S3;
                else
                    state_nxt = ST_S0;
            end
            ST_S2: begin
                if (!dmao_n)
                    state_nxt = ST_S2;
                else if (int_req && ie_q)
                    state_nxt = ST_S3;
                else
                    state_nxt = ST_S0;
            end
            ST_S3: begin
                if (!dmao_n)
                    state_nxt = ST_S2;
                else
                    state_nxt = ST_S0;
            end
            default: state_nxt = ST_S0;
        endcase
    end

    // Per-tick actions; everything (including core writes) is frozen while
    // clk_enable is low, and the pulse outputs default to 0.
    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        r0_d         = r0_q;
        ie_d         = ie_q;
        mem_addr_d   = mem_addr_q;
        dma_data_d   = dma_data_q;
        mem_rd_d     = 1'b0;
        dma_strobe_d = 1'b0;
        int_ack_d    = 1'b0;

        if (clk_enable) begin
            tick_d = cycle_end ? 3'd0 : tick_q + 3'd1;

            // The core is stalled in S2/S3, so its R0 writes only count in S0/S1.
            if (r0_wr && (state_q == ST_S0 || state_q == ST_S1))
                r0_d = r0_wdata;

            if (ie_set)
                ie_d = 1'b1;

            case (state_q)
                ST_S2: begin
                    if (tick_q == ADDR_T) begin
                        mem_addr_d = r0_q;
                        mem_rd_d   = 1'b1;
                    end
                    if (tick_q == DATA_T) begin
                        dma_data_d   = mem_data;
                        dma_strobe_d = 1'b1;
                    end
                    if (cycle_end)
                        r0_d = r0_inc(r0_q);
                end
                ST_S3: begin
                    // Placed after the ie_set term so the acknowledge clear wins.
                    if (tick_q == 3'd0) begin
                        int_ack_d = 1'b1;
                        ie_d      = 1'b0;
                    end
                end
                default: ;
            endcase

            if (cycle_end)
                state_d = state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_S1;
            tick_q       <= 3'd0;
            r0_q         <= 16'h0000;
            ie_q         <= 1'b1;
            mem_addr_q   <= 16'h0000;
            dma_data_q   <= 8'h00;
            mem_rd_q     <= 1'b0;
            dma_strobe_q <= 1'b0;
            int_ack_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            r0_q         <= r0_d;
            ie_q         <= ie_d;
            mem_addr_q   <= mem_addr_d;
            dma_data_q   <= dma_data_d;
            mem_rd_q     <= mem_rd_d;
            dma_strobe_q <= dma_strobe_d;
            int_ack_q    <= int_ack_d;
        end
    end

    assign SC         = state_q;
    assign mem_addr   = mem_addr_q;
    assign mem_rd     = mem_rd_q;
    assign dma_data   = dma_data_q;
    assign dma_strobe = dma_strobe_q;
    assign int_ack    = int_ack_q;
    assign r0         = r0_q;
    assign ie         = ie_q;

endmodule

// File: tb/tb_cdp1802_dma_out_responder.sv
// -----------------------------------------------------------------------------
// Bench for cdp1802_dma_out_responder. DMA runs come from a table of
// {R0 start, byte count, final R0}; expected DMA addresses and bytes go into
// scoreboard queues that a monitor drains on each mem_rd / dma_strobe.
// Interrupt, reset-abort, clock-enable freeze, ignored R0 writes and
// core_hold are covered by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_cdp1802_dma_out_responder;

    logic        clk = 1'b0;
    logic        reset, clk_enable, dmao_n, int_req, core_hold, r0_wr, ie_set;
    logic [15:0] r0_wdata;
    logic [7:0]  mem_data;
    logic [1:0]  SC;
    logic [15:0] mem_addr, r0;
    logic        mem_rd, dma_strobe, int_ack, ie;
    logic [7:0]  dma_data;

    cdp1802_dma_out_responder dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .dmao_n     (dmao_n),
        .int_req    (int_req),
        .core_hold  (core_hold),
        .r0_wr      (r0_wr),
        .r0_wdata   (r0_wdata),
        .ie_set     (ie_set),
        .mem_data   (mem_data),
        .SC         (SC),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .dma_data   (dma_data),
        .dma_strobe (dma_strobe),
        .int_ack    (int_ack),
        .r0         (r0),
        .ie         (ie)
    );

    initial forever #5 clk = ~clk;

    // Memory contents: an address-dependent pattern, so a wrong address shows.
    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
    endfunction
    assign mem_data = mem_byte(mem_addr);

    int n_vec   = 0;
    int n_fail  = 0;
    int tick_m  = 0;
    int ack_cnt = 0;
    logic [15:0] exp_addr_q[$];
    logic [7:0]  exp_data_q[$];

    typedef struct {
        logic [15:0] r0_init;
        int          nbytes;
        logic [15:0] exp_r0;
    } dma_vec_t;

    dma_vec_t vecs[4];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (clk_enable) tick_m = (tick_m + 1) % 8;
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic wait_start(input logic [1:0] s, input string nm);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            if (tick_m == 0 && SC == s) found = 1'b1;
            else step();
        end
        if (!found) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s: SC=%0d, never reached start of state %0d", nm, SC, s);
        end
    endtask

    task automatic write_r0(input logic [15:0] v);
        r0_wr    = 1'b1;
        r0_wdata = v;
        step();
        r0_wr    = 1'b0;
    endtask

    // Monitor: every read strobe and data strobe must match the scoreboard.
    initial begin
        bit prev_rd, prev_st;
        prev_rd = 1'b0;
        prev_st = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_rd === 1'b1) begin
                if (prev_rd) begin
                    n_vec++; n_fail++;
                    $display("FAIL mem_rd_width: high 2 clocks, expected 1");
                end
                if (exp_addr_q.size() == 0) begin
                    n_vec++; n_fail++;
                    $display("FAIL mem_rd_unexpected: addr %0h, expected no read", mem_addr);
                end else
                    check("dma_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
            end
            if (dma_strobe === 1'b1) begin
                if (prev_st) begin
                    n_vec++; n_fail++;
                    $display("FAIL dma_strobe_width: high 2 clocks, expected 1");
                end
                if (exp_data_q.size() == 0) begin
                    n_vec++; n_fail++;
                    $display("FAIL dma_strobe_unexpected: data %0h, expected no strobe", dma_data);
                end else
                    check("dma_data", 32'(dma_data), 32'(exp_data_q.pop_front()));
            end
            prev_rd = (mem_rd === 1'b1);
            prev_st = (dma_strobe === 1'b1);
            if (int_ack === 1'b1) ack_cnt++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] e;
        vecs[0] = '{16'h0900, 8, 16'h0908};
        vecs[1] = '{16'hFFFE, 2, 16'h0000};
        vecs[2] = '{16'h1234, 1, 16'h1235};
        vecs[3] = '{16'h7FFF, 3, 16'h8002};

        reset = 1'b0; clk_enable = 1'b1; dmao_n = 1'b1; int_req = 1'b0;
        core_hold = 1'b0; r0_wr = 1'b0; r0_wdata = 16'h0; ie_set = 1'b0;
        steps(3);
        reset = 1'b1;
        tick_m = 0;

        // Reset state
        check("rst_sc",       32'(SC), 32'h1);
        check("rst_r0",       32'(r0), 32'h0);
        check("rst_ie",       32'(ie), 32'h1);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_dma_data", 32'(dma_data), 32'h0);
        check("rst_mem_rd",   32'(mem_rd), 32'h0);
        check("rst_strobe",   32'(dma_strobe), 32'h0);
        check("rst_int_ack",  32'(int_ack), 32'h0);

        // Idle S1/S0 alternation, 8 ticks each
        for (int c = 0; c < 4; c++) begin
            check("seq_first_tick", 32'(SC), (c % 2 == 0) ? 32'h1 : 32'h0);
            steps(7);
            check("seq_last_tick",  32'(SC), (c % 2 == 0) ? 32'h1 : 32'h0);
            step();
        end
        check("seq_r0", 32'(r0), 32'h0);

        // Table-driven DMA runs
        for (int v = 0; v < 4; v++) begin
            wait_start(2'b01, "dma_s1");
            write_r0(vecs[v].r0_init);
            check("dma_r0_load", 32'(r0), 32'(vecs[v].r0_init));
            dmao_n = 1'b0;
            for (int k = 0; k < vecs[v].nbytes; k++) begin
                e = vecs[v].r0_init + 16'(k);
                exp_addr_q.push_back(e);
                exp_data_q.push_back(mem_byte(e));
            end
            wait_start(2'b10, "dma_s2");
            for (int k = 1; k <= vecs[v].nbytes; k++) begin
                e = vecs[v].r0_init + 16'(k - 1);
                check("dma_sc", 32'(SC), 32'h2);
                check("dma_r0_run", 32'(r0), 32'(e));
                if (k == vecs[v].nbytes) dmao_n = 1'b1;
                steps(8);
            end
            check("dma_after_sc", 32'(SC), 32'h0);
            check("dma_final_r0", 32'(r0), 32'(vecs[v].exp_r0));
        end
        check("dma_addr_drained", 32'(exp_addr_q.size()), 32'h0);
        check("dma_data_drained", 32'(exp_data_q.size()), 32'h0);

        // DMA and INT at the same S1 end: DMA first, then one S3
        wait_start(2'b01, "int_s1");
        int_req = 1'b1;
        dmao_n  = 1'b0;
        exp_addr_q.push_back(16'h8002);
        exp_data_q.push_back(mem_byte(16'h8002));
        wait_start(2'b10, "int_dma_first");
        dmao_n = 1'b1;
        steps(8);
        check("int_s3",          32'(SC), 32'h3);
        check("int_ack_tick0",   32'(int_ack), 32'h0);
        step();
        check("int_ack_pulse",   32'(int_ack), 32'h1);
        check("int_ie_cleared",  32'(ie), 32'h0);
        step();
        check("int_ack_single",  32'(int_ack), 32'h0);
        steps(6);
        check("int_after_s3",    32'(SC), 32'h0);
        steps(8);
        check("int_next_s1",     32'(SC), 32'h1);
        steps(8);
        check("int_no_second_s3", 32'(SC), 32'h0);
        check("int_ack_count1",  32'(ack_cnt), 32'h1);
        check("int_r0",          32'(r0), 32'h8003);

        // r0_wr and ie_set together in S0
        r0_wr = 1'b1; r0_wdata = 16'h4000; ie_set = 1'b1;
        step();
        r0_wr = 1'b0; ie_set = 1'b0;
        check("both_r0", 32'(r0), 32'h4000);
        check("both_ie", 32'(ie), 32'h1);

        // ie_set held across S3 entry: the acknowledge clear wins
        wait_start(2'b01, "iewin_s1");
        steps(7);
        ie_set = 1'b1;
        step();
        check("iewin_s3", 32'(SC), 32'h3);
        step();
        check("iewin_ie",  32'(ie), 32'h0);
        check("iewin_ack", 32'(int_ack), 32'h1);
        ie_set = 1'b0;
        int_req = 1'b0;
        wait_start(2'b00, "iewin_s0");
        check("int_ack_count2", 32'(ack_cnt), 32'h2);
        ie_set = 1'b1;
        step();
        ie_set = 1'b0;
        check("ie_restore", 32'(ie), 32'h1);

        // r0_wr during S2 ignored
        wait_start(2'b01, "ign_s1");
        write_r0(16'h2222);
        dmao_n = 1'b0;
        exp_addr_q.push_back(16'h2222);
        exp_data_q.push_back(mem_byte(16'h2222));
        wait_start(2'b10, "ign_s2");
        dmao_n = 1'b1;
        steps(2);
        r0_wr = 1'b1; r0_wdata = 16'h5555;
        step();
        r0_wr = 1'b0;
        check("ign_r0_in_s2", 32'(r0), 32'h2222);
        wait_start(2'b00, "ign_s0");
        check("ign_r0_inc", 32'(r0), 32'h2223);

        // core_hold stretches S1
        wait_start(2'b01, "hold_s1");
        core_hold = 1'b1;
        steps(8);
        check("hold_second_s1", 32'(SC), 32'h1);
        core_hold = 1'b0;
        steps(8);
        check("hold_then_s0", 32'(SC), 32'h0);

        // clk_enable low for 20 clocks mid-S2
        wait_start(2'b01, "frz_s1");
        write_r0(16'h0ABC);
        dmao_n = 1'b0;
        exp_addr_q.push_back(16'h0ABC);
        exp_data_q.push_back(mem_byte(16'h0ABC));
        wait_start(2'b10, "frz_s2");
        dmao_n = 1'b1;
        steps(2);
        clk_enable = 1'b0;
        steps(20);
        check("frz_sc",       32'(SC), 32'h2);
        check("frz_r0",       32'(r0), 32'h0ABC);
        check("frz_mem_addr", 32'(mem_addr), 32'h2222);
        clk_enable = 1'b1;
        steps(6);
        check("frz_resume_sc", 32'(SC), 32'h0);
        check("frz_resume_r0", 32'(r0), 32'h0ABD);

        // Reset at tick 4 of S2: read issued, no strobe, no increment
        wait_start(2'b01, "rst2_s1");
        dmao_n = 1'b0;
        exp_addr_q.push_back(16'h0ABD);
        wait_start(2'b10, "rst2_s2");
        steps(4);
        reset = 1'b0;
        step();
        reset  = 1'b1;
        dmao_n = 1'b1;
        tick_m = 0;
        check("rst2_sc",       32'(SC), 32'h1);
        check("rst2_r0",       32'(r0), 32'h0);
        check("rst2_dma_data", 32'(dma_data), 32'h0);
        check("rst2_mem_addr", 32'(mem_addr), 32'h0);
        check("rst2_ie",       32'(ie), 32'h1);
        steps(8);
        check("rst2_next_s0",  32'(SC), 32'h0);

        check("final_addr_drained", 32'(exp_addr_q.size()), 32'h0);
        check("final_data_drained", 32'(exp_data_q.size()), 32'h0);
        check("final_ack_count",    32'(ack_cnt), 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
